// File: rtl/img_readout_dma.sv
// Frame readout DMA: fetches rows from a row memory and streams them out as a
// valid/ready pixel stream. Define IMG_READOUT_PREFETCH_EN for bubble-free rows.
module img_readout_dma #(
  parameter int PIX_W    = 12,
  parameter int ROW_PIX  = 256,
  parameter int NUM_ROWS = 240
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  output logic                     busy,
  output logic                     done,
  output logic                     re,
  output logic [8:0]               raddr,
  input  logic [PIX_W*ROW_PIX-1:0] rdata_in,
  output logic                     pix_valid,
  input  logic                     pix_ready,
  output logic [PIX_W-1:0]         pix_data,
  output logic                     pix_eol,
  output logic                     pix_eof
);

  localparam int ROW_BITS = PIX_W * ROW_PIX;
  localparam int COL_W    = (ROW_PIX > 1) ? $clog2(ROW_PIX) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(ROW_PIX - 1);
  localparam logic [8:0]       ROW_LAST = 9'(NUM_ROWS - 1);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, STREAM, FIN} state_t;

  state_t              state_q, state_d;
  logic [8:0]          row_q, row_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [ROW_BITS-1:0] row_buf_q;

  logic hs, row_end, last_row;
  logic swap, pf_re;

  assign hs       = pix_valid && pix_ready;
  assign row_end  = hs && (col_q == COL_LAST);
  assign last_row = (row_q == ROW_LAST);

`ifdef IMG_READOUT_PREFETCH_EN
  logic [ROW_BITS-1:0] shadow_q;
  logic pf_req_q, pf_req_d;
  logic pf_wait_q, pf_wait_d;
  logic shadow_vld_q, shadow_vld_d;

  assign pf_re = (state_q == STREAM) && pf_req_q;
  // A row boundary only skips FETCH/LOAD when the next row already sits in the shadow.
  assign swap  = row_end && !last_row && shadow_vld_q;

  always_comb begin
    pf_req_d     = 1'b0;
    pf_wait_d    = pf_re;
    shadow_vld_d = shadow_vld_q;
    if (pf_wait_q) shadow_vld_d = 1'b1;
    if ((state_q == LOAD) && !last_row) pf_req_d = 1'b1;
    if (swap) begin
      shadow_vld_d = 1'b0;
      pf_req_d     = ((row_q + 9'd1) != ROW_LAST);
    end else if (row_end || (state_q != STREAM)) begin
      // Fallback to a normal fetch (or frame end): drop any in-flight prefetch.
      shadow_vld_d = 1'b0;
      pf_wait_d    = 1'b0;
      if (state_q == LOAD && !last_row) pf_req_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pf_req_q     <= 1'b0;
      pf_wait_q    <= 1'b0;
      shadow_vld_q <= 1'b0;
    end else begin
      pf_req_q     <= pf_req_d;
      pf_wait_q    <= pf_wait_d;
      shadow_vld_q <= shadow_vld_d;
    end
  end

  always_ff @(posedge clk) begin
    if (pf_wait_q) shadow_q <= rdata_in;
  end
`else
  assign pf_re = 1'b0;
  assign swap  = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = FETCH;
          row_d   = '0;
          col_d   = '0;
        end
      end
      FETCH:  state_d = LOAD;
      LOAD:   state_d = STREAM;
      STREAM: begin
        if (hs) begin
          col_d = (col_q == COL_LAST) ? '0 : col_q + 1'b1;
          if (row_end) begin
            if (last_row) begin
              state_d = FIN;
              row_d   = '0;
            end else begin
              row_d = row_q + 9'd1;
              if (!swap) state_d = FETCH;
            end
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == LOAD) row_buf_q <= rdata_in;
`ifdef IMG_READOUT_PREFETCH_EN
    else if (swap) row_buf_q <= shadow_q;
`endif
  end

  assign busy      = (state_q == FETCH) || (state_q == LOAD) || (state_q == STREAM);
  assign done      = (state_q == FIN);
  assign pix_valid = (state_q == STREAM);
  assign re        = (state_q == FETCH) || pf_re;
  assign raddr     = pf_re ? (row_q + 9'd1) : row_q;
  assign pix_data  = row_buf_q[PIX_W*col_q +: PIX_W];
  assign pix_eol   = pix_valid && (col_q == COL_LAST);
  assign pix_eof   = pix_eol && last_row;

endmodule
